// File: rtl/branch_recovery.sv
`default_nettype none
// ============================================================================
// Module      : branch_recovery
// Description : Fetch-side branch recovery. Records every branch predicted in
//               ID in an in-order in-flight queue, checks the MEM-stage
//               resolution against the queue head and, on a mispredict,
//               issues a registered PC redirect, flush pulses and a squash
//               window during which ID pushes and MEM resolutions are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_recovery #(
    parameter int DEPTH         = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_branch,
    input  logic [31:0] id_pc,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    input  logic        me_branch,
    input  logic        me_taken,
    input  logic [31:0] me_target,
    input  logic [31:0] me_pc_next,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_me,
    output logic        squashing,
    output logic        q_full,
    output logic        q_empty,
    output logic [15:0] mispredict_count,
    output logic        order_error
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SQ_W  = $clog2(SQUASH_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_SQ_W-1:0]  c_SQ_LOAD  = c_SQ_W'(SQUASH_CYCLES - 1);
    localparam logic [c_SQ_W-1:0]  c_SQ_ONE   = c_SQ_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REDIRECT = 2'd1;
    localparam logic [1:0] c_SQUASH   = 2'd2;

    // Queue storage (no reset needed: validity is tracked by the pointers)
    logic [31:0]        r_q_pc    [DEPTH];
    logic               r_q_taken [DEPTH];
    logic [31:0]        r_q_tgt   [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_state;
    logic [c_SQ_W-1:0]  r_sq_cnt;
    logic [31:0]        r_redirect_pc;
    logic [15:0]        r_mcount;
    logic               r_order_err;

    logic               w_in_idle;
    logic               w_full;
    logic               w_empty;
    logic               w_pop_ok;
    logic               w_push_ok;
    logic               w_mispredict;
    logic               w_order_viol;
    logic [31:0]        w_head_pc;
    logic               w_head_taken;
    logic [31:0]        w_head_tgt;

    // Queue status, head decode and the accept / mispredict / violation terms
    always_comb begin
        w_in_idle    = (r_state == c_IDLE);
        w_full       = (r_count == c_FULL_CNT);
        w_empty      = (r_count == '0);
        w_head_pc    = r_q_pc[r_head];
        w_head_taken = r_q_taken[r_head];
        w_head_tgt   = r_q_tgt[r_head];
        w_pop_ok     = w_in_idle && me_branch && !w_empty;
        // A push into a full queue is fine when the head leaves the same cycle
        w_push_ok    = w_in_idle && id_branch && (!w_full || w_pop_ok);
        w_mispredict = w_pop_ok &&
                       ((me_taken != w_head_taken) ||
                        (me_taken && (w_head_tgt != me_target)));
        // Head PC mismatch is flagged but the outcome is still evaluated
        w_order_viol = w_in_idle &&
                       ((id_branch && w_full && !w_pop_ok) ||
                        (me_branch && w_empty) ||
                        (w_pop_ok && (w_head_pc != (me_pc_next - 32'd4))));
    end

    // Entry write at the tail
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_q_pc[r_tail]    <= id_pc;
            r_q_taken[r_tail] <= id_pred_taken;
            r_q_tgt[r_tail]   <= id_pred_target;
        end
    end

    // Queue pointers/count; a mispredict discards every entry including a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispredict) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Recovery state machine: IDLE -> REDIRECT (1 cycle) -> SQUASH -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_sq_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_mispredict) begin
                        r_state <= c_REDIRECT;
                    end
                end
                c_REDIRECT: begin
                    r_state  <= c_SQUASH;
                    r_sq_cnt <= c_SQ_LOAD;
                end
                c_SQUASH: begin
                    if (r_sq_cnt == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_sq_cnt <= r_sq_cnt - c_SQ_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Corrected fetch PC and saturating mispredict counter, captured at the resolving edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pc <= '0;
            r_mcount      <= '0;
        end else if (w_mispredict) begin
            r_redirect_pc <= me_taken ? me_target : me_pc_next;
            if (r_mcount != 16'hFFFF) begin
                r_mcount <= r_mcount + 16'd1;
            end
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_order_err <= 1'b0;
        end else if (w_order_viol) begin
            r_order_err <= 1'b1;
        end
    end

    assign redirect_valid   = (r_state == c_REDIRECT);
    assign flush_if_id      = (r_state == c_REDIRECT);
    assign flush_id_ex      = (r_state == c_REDIRECT);
    assign flush_ex_me      = (r_state == c_REDIRECT);
    assign squashing        = (r_state == c_SQUASH);
    assign redirect_pc      = r_redirect_pc;
    assign q_full           = w_full;
    assign q_empty          = w_empty;
    assign mispredict_count = r_mcount;
    assign order_error      = r_order_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_recovery.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_recovery
// Description : Self-checking bench for branch_recovery. A queue-based model
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_recovery;

    localparam int DEPTH = 4;
    localparam int SQ    = 2;

    logic        clk;
    logic        rst_n;
    logic        id_branch;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        me_branch;
    logic        me_taken;
    logic [31:0] me_target;
    logic [31:0] me_pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_me;
    logic        squashing;
    logic        q_full;
    logic        q_empty;
    logic [15:0] mispredict_count;
    logic        order_error;

    branch_recovery #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQ)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_branch        (id_branch),
        .id_pc            (id_pc),
        .id_pred_taken    (id_pred_taken),
        .id_pred_target   (id_pred_target),
        .me_branch        (me_branch),
        .me_taken         (me_taken),
        .me_target        (me_target),
        .me_pc_next       (me_pc_next),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .flush_ex_me      (flush_ex_me),
        .squashing        (squashing),
        .q_full           (q_full),
        .q_empty          (q_empty),
        .mispredict_count (mispredict_count),
        .order_error      (order_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
    } ent_t;

    ent_t        mq[$];
    int          m_busy;   // cycles remaining before branches are accepted again
    logic [31:0] m_rpc;
    logic [15:0] m_cnt;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_busy = 0;
            m_rpc  = 32'h0;
            m_cnt  = 16'h0;
            m_err  = 1'b0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end else begin
            bit   pop_ok;
            bit   mis;
            ent_t h;
            ent_t e;
            pop_ok = me_branch && (mq.size() > 0);
            mis    = 1'b0;
            if (me_branch && mq.size() == 0) m_err = 1'b1;
            if (id_branch && mq.size() == DEPTH && !pop_ok) m_err = 1'b1;
            if (pop_ok) begin
                h = mq[0];
                if (h.pc != me_pc_next - 32'd4) m_err = 1'b1;
                mis = (me_taken != h.tk) || (me_taken && h.tg != me_target);
            end
            if (mis) begin
                mq.delete();
                m_busy = 1 + SQ;
                m_rpc  = me_taken ? me_target : me_pc_next;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                if (pop_ok) void'(mq.pop_front());
                if (id_branch && mq.size() < DEPTH) begin
                    e.pc = id_pc;
                    e.tk = id_pred_taken;
                    e.tg = id_pred_target;
                    mq.push_back(e);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic rv;
        rv = (m_busy == SQ + 1);
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, rv});
        chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, rv});
        chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, rv});
        chk("flush_ex_me", {31'd0, flush_ex_me}, {31'd0, rv});
        chk("squashing", {31'd0, squashing}, {31'd0, (m_busy >= 1 && m_busy <= SQ)});
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("q_full", {31'd0, q_full}, {31'd0, (mq.size() == DEPTH)});
        chk("q_empty", {31'd0, q_empty}, {31'd0, (mq.size() == 0)});
        chk("mispredict_count", {16'd0, mispredict_count}, {16'd0, m_cnt});
        chk("order_error", {31'd0, order_error}, {31'd0, m_err});
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic ib, input logic [31:0] ipc, input logic itk,
                        input logic [31:0] itg, input logic mb, input logic mtk,
                        input logic [31:0] mtg, input logic [31:0] mnx);
        id_branch      = ib;
        id_pc          = ipc;
        id_pred_taken  = itk;
        id_pred_target = itg;
        me_branch      = mb;
        me_taken       = mtk;
        me_target      = mtg;
        me_pc_next     = mnx;
        @(posedge clk);
        #1;
        id_branch = 1'b0;
        me_branch = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        step(1'b1, pc, tk, tg, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pop(input logic tk, input logic [31:0] tg, input logic [31:0] nx);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, tk, tg, nx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        id_branch = 1'b0; id_pc = '0; id_pred_taken = 1'b0; id_pred_target = '0;
        me_branch = 1'b0; me_taken = 1'b0; me_target = '0; me_pc_next = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst q_empty", {31'd0, q_empty}, 32'd1);
        chk("rst redirect_pc", redirect_pc, 32'h0);
        chk("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Correct taken branch
        push(32'h100, 1'b1, 32'h200);
        idle(1);
        pop(1'b1, 32'h200, 32'h104);
        chk("ok redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("ok q_empty", {31'd0, q_empty}, 32'd1);

        // Direction mispredict
        push(32'h100, 1'b1, 32'h200);
        idle(1);
        pop(1'b0, 32'h0, 32'h104);
        chk("dir redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("dir redirect_pc", redirect_pc, 32'h104);
        chk("dir flush_ex_me", {31'd0, flush_ex_me}, 32'd1);
        chk("dir mispredict_count", {16'd0, mispredict_count}, 32'd1);
        idle(1);
        chk("dir squash1", {31'd0, squashing}, 32'd1);
        chk("dir redirect pulse", {31'd0, redirect_valid}, 32'd0);
        idle(1);
        chk("dir squash2", {31'd0, squashing}, 32'd1);
        idle(1);
        chk("dir squash end", {31'd0, squashing}, 32'd0);

        // Target mispredict with a younger entry; pushes during recovery ignored
        push(32'h100, 1'b1, 32'h200);
        push(32'h110, 1'b1, 32'h210);
        pop(1'b1, 32'h300, 32'h104);
        chk("tgt redirect_pc", redirect_pc, 32'h300);
        chk("tgt q_empty", {31'd0, q_empty}, 32'd1);
        push(32'h120, 1'b0, 32'h0);
        push(32'h130, 1'b0, 32'h0);
        push(32'h140, 1'b0, 32'h0);
        chk("tgt squash push ignored", {31'd0, q_empty}, 32'd1);
        chk("tgt mispredict_count", {16'd0, mispredict_count}, 32'd2);
        chk("tgt redirect_pc hold", redirect_pc, 32'h300);

        // Full queue, push with pop when full, dropped push
        push(32'h10, 1'b0, 32'h999);
        push(32'h14, 1'b0, 32'h999);
        push(32'h18, 1'b0, 32'h999);
        push(32'h1C, 1'b0, 32'h999);
        chk("full q_full", {31'd0, q_full}, 32'd1);
        step(1'b1, 32'h20, 1'b0, 32'h999, 1'b1, 1'b0, 32'h0, 32'h14);
        chk("full push+pop q_full", {31'd0, q_full}, 32'd1);
        chk("full push+pop order_error", {31'd0, order_error}, 32'd0);
        push(32'h24, 1'b0, 32'h999);
        chk("full drop order_error", {31'd0, order_error}, 32'd1);
        pop(1'b0, 32'h0, 32'h18);
        pop(1'b0, 32'h0, 32'h1C);
        pop(1'b0, 32'h0, 32'h20);
        pop(1'b0, 32'h0, 32'h24);
        chk("full drained", {31'd0, q_empty}, 32'd1);

        // Simultaneous push/pop with one entry
        push(32'h40, 1'b1, 32'h80);
        step(1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h44);
        chk("one push+pop q_empty", {31'd0, q_empty}, 32'd0);
        pop(1'b0, 32'h0, 32'h48);
        chk("one drained", {31'd0, q_empty}, 32'd1);

        // Head PC mismatch
        do_reset();
        chk("order rst order_error", {31'd0, order_error}, 32'd0);
        push(32'h100, 1'b0, 32'h0);
        pop(1'b0, 32'h0, 32'h204);
        chk("order pc order_error", {31'd0, order_error}, 32'd1);
        chk("order pc no redirect", {31'd0, redirect_valid}, 32'd0);

        // Pop while empty
        do_reset();
        pop(1'b1, 32'h500, 32'h504);
        chk("empty pop order_error", {31'd0, order_error}, 32'd1);
        chk("empty pop no redirect", {31'd0, redirect_valid}, 32'd0);

        // Asynchronous reset during the redirect cycle
        push(32'h100, 1'b1, 32'h200);
        pop(1'b0, 32'h0, 32'h104);
        chk("arst pre redirect_valid", {31'd0, redirect_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst flush_if_id", {31'd0, flush_if_id}, 32'd0);
        chk("arst redirect_pc", redirect_pc, 32'h0);
        chk("arst mispredict_count", {16'd0, mispredict_count}, 32'd0);
        chk("arst q_empty", {31'd0, q_empty}, 32'd1);
        chk("arst order_error", {31'd0, order_error}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'h300, 1'b0, 32'h0);
        pop(1'b0, 32'h0, 32'h304);
        chk("arst idle redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst idle squashing", {31'd0, squashing}, 32'd0);
        chk("arst idle q_empty", {31'd0, q_empty}, 32'd1);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_recovery.md
Name: branch_recovery

Overview:
- Fetch-side consumer of branch predictions.
- Each branch predicted in ID is recorded in an in-order in-flight queue: PC, predicted direction and predicted target.
- When a branch resolves in MEM, the block compares the actual outcome against the queue head. On a mismatch it issues a registered PC redirect, pipeline flush pulses and a squash window.
- Sits between the ID-stage predictor lookup, the MEM-stage branch resolution and the IF-stage PC mux.

Parameters:
- DEPTH, 4, in-flight queue entries; power of two, ≥2.
- SQUASH_CYCLES, 2, cycles after redirect during which ID pushes and MEM resolutions are ignored; ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_branch  input  1  conditional branch decoded in ID this cycle
- id_pc  input  32  PC of that branch
- id_pred_taken  input  1  predicted direction
- id_pred_target  input  32  predicted/decoded target
- me_branch  input  1  branch resolving in MEM this cycle
- me_taken  input  1  actual outcome (branch & zero)
- me_target  input  32  actual target
- me_pc_next  input  32  branch PC + 4
- redirect_valid  output  1  one-cycle pulse: IF must load redirect_pc
- redirect_pc  output  32  corrected fetch PC
- flush_if_id  output  1  flush pulse, coincident with redirect_valid
- flush_id_ex  output  1  flush pulse, coincident with redirect_valid
- flush_ex_me  output  1  flush pulse, coincident with redirect_valid
- squashing  output  1  high while in SQUASH
- q_full  output  1  queue full
- q_empty  output  1  queue empty
- mispredict_count  output  16  saturating mispredict counter
- order_error  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n=0): all 1-bit outputs 0 except q_empty=1; redirect_pc=0; mispredict_count=0; queue pointers and count=0; state=IDLE. Reset mid-redirect or mid-squash abandons the operation immediately.
- Queue entry: {pc[31:0], pred_taken, pred_target[31:0]}. Circular buffer; count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
- States: IDLE, REDIRECT, SQUASH.
- IDLE, push: id_branch=1 and queue not full → write entry at tail.
- IDLE, push when full with no simultaneous pop: entry dropped, order_error←1.
- IDLE, pop: me_branch=1 and queue not empty → pop head.
- IDLE, simultaneous push and pop: both occur, count unchanged. This holds when full and when count=1.
- IDLE, pop while empty: no redirect, order_error←1.
- Head check on pop: head.pc != me_pc_next-4 (32-bit wrap arithmetic) → order_error←1. Mispredict evaluation still proceeds.
- Mispredict conditions: me_taken != head.pred_taken, or (me_taken=1 and head.pred_target != me_target).
- On mispredict:
  - Next state REDIRECT.
  - redirect_pc registered as me_target if me_taken, else me_pc_next.
  - mispredict_count += 1, saturating at 0xFFFF.
  - Whole queue cleared at that edge, including any same-cycle push: younger entries are wrong-path.
- REDIRECT (exactly 1 cycle): redirect_valid=flush_if_id=flush_id_ex=flush_ex_me=1; id_branch and me_branch ignored; next state SQUASH. Latency: resolving edge → redirect visible the following cycle.
- SQUASH: squashing=1; SQUASH_CYCLES-cycle down-counter; id_branch and me_branch ignored; returns to IDLE when the counter reaches 0. redirect_pc holds its value.
- Correct prediction: no outputs change except queue pop; state stays IDLE.
- order_error clears only on reset.

Test Plan:
- Correct taken branch: push {pc=0x100, taken=1, tgt=0x200}; 2 cycles later resolve me_taken=1, me_target=0x200, me_pc_next=0x104 → no redirect, q_empty=1, count=0.
- Direction mispredict: push {0x100, taken=1, 0x200}; resolve me_taken=0, me_pc_next=0x104 → next cycle redirect_valid=1, redirect_pc=0x104, all three flushes=1 for 1 cycle; squashing=1 for 2 cycles; mispredict_count=1.
- Target mispredict with younger entries: push 0x100 and 0x110, both pred taken; resolve 0x100 taken, target 0x300 ≠ 0x200 → redirect_pc=0x300, queue empty afterwards; push during squash ignored (q_empty stays 1).
- Full queue: 4 pushes → q_full=1; 5th push with simultaneous pop → accepted, count stays 4; 5th push without pop → dropped, order_error=1.
- Order check: pop with me_pc_next=0x204 when head pc=0x100 → order_error=1; pop while empty → order_error=1, no redirect.
- Async reset asserted in REDIRECT cycle → all outputs return to reset values immediately without waiting for clk; after release, mispredict_count=0 and state=IDLE.
